// File: rtl/udt_close_handler.sv
// UDT CLOSE control-packet processor: validates the header, matches the destination socket
// against the connection table and emits one state-update record per accepted CLOSE.
module udt_close_handler #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_CONN    = 4,
    parameter int unsigned IDX_W       = 2,
    parameter logic [14:0] CLOSE_TYPE  = 15'd5,
    parameter logic [31:0] BROKEN_CODE = 32'd6,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   core_clk,
    input  logic                   core_rst_n,
    input  logic                   close_tvalid_i,
    input  logic [DATA_W-1:0]      close_tdata_i,
    input  logic [DATA_W/8-1:0]    close_tkeep_i,
    input  logic                   close_tlast_i,
    output logic                   close_tready_o,
    input  logic [NUM_CONN*32-1:0] conn_sock_id_i,
    input  logic [NUM_CONN-1:0]    conn_active_i,
    output logic [31:0]            udt_state_o,
    output logic [IDX_W-1:0]       conn_idx_o,
    output logic [31:0]            close_ts_o,
    output logic                   state_valid_o,
    input  logic                   state_ready_i,
    output logic [CNT_W-1:0]       close_cnt_o,
    output logic [CNT_W-1:0]       drop_cnt_o
);

    localparam bit TwoBeat = (DATA_W == 64);

    typedef enum logic [1:0] {StIdle, StHdr1, StDrain, StEmit} state_e;

    state_e            state_q;
    logic              tready_q;
    logic              valid_q;
    logic              ok_q;
    logic [63:0]       hi_q;
    logic              keep0_q;
    logic [31:0]       udt_state_q;
    logic [IDX_W-1:0]  conn_idx_q;
    logic [31:0]       close_ts_q;
    logic [CNT_W-1:0]  close_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic [127:0]      tdata_x;
    logic [15:0]       keep_x;
    logic [127:0]      hdr;
    logic              keep_ok;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              hs;
    logic              eval;
    logic              hdr_ok;
    logic              runt;
    logic              drain_end;
    logic              emit_now;
    logic              drop_now;

    assign tdata_x = 128'(close_tdata_i);
    assign keep_x  = 16'(close_tkeep_i);

    // The narrow stream assembles the header from the latched first beat plus the current one.
    assign hdr     = TwoBeat ? {hi_q, tdata_x[63:0]} : tdata_x;
    assign keep_ok = TwoBeat ? (keep0_q & (&keep_x[7:0])) : (&keep_x);

    // Scan downwards so the lowest matching live slot wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_CONN - 1; k >= 0; k--) begin
            if (conn_active_i[k] && (conn_sock_id_i[32*k +: 32] == hdr[31:0])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    assign hs        = close_tvalid_i && tready_q;
    assign eval      = hs && (((state_q == StIdle) && !TwoBeat) || (state_q == StHdr1));
    assign hdr_ok    = hdr[127] && (hdr[126:112] == CLOSE_TYPE) && keep_ok && hit;
    assign runt      = hs && close_tlast_i && (state_q == StIdle) && TwoBeat;
    assign drain_end = hs && close_tlast_i && (state_q == StDrain);
    assign emit_now  = (eval && close_tlast_i && hdr_ok) || (drain_end && ok_q);
    assign drop_now  = runt || (eval && close_tlast_i && !hdr_ok) || (drain_end && !ok_q);

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q     <= StIdle;
            tready_q    <= 1'b0;
            valid_q     <= 1'b0;
            ok_q        <= 1'b0;
            hi_q        <= '0;
            keep0_q     <= 1'b0;
            udt_state_q <= '0;
            conn_idx_q  <= '0;
            close_ts_q  <= '0;
            close_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            tready_q <= (state_q == StEmit) ? state_ready_i : !emit_now;
            unique case (state_q)
                StIdle: begin
                    if (hs && TwoBeat) begin
                        hi_q    <= tdata_x[63:0];
                        keep0_q <= &keep_x[7:0];
                        if (!close_tlast_i) state_q <= StHdr1;
                    end
                end
                StHdr1, StDrain: ;
                StEmit: begin
                    if (state_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                        if (close_cnt_q != '1) close_cnt_q <= close_cnt_q + 1'b1;
                    end
                end
            endcase
            // Record fields are captured at the header's last beat; later table changes are ignored.
            if (eval) begin
                ok_q    <= hdr_ok;
                state_q <= StDrain;
                if (hdr_ok) begin
                    conn_idx_q <= hit_idx;
                    close_ts_q <= hdr[63:32];
                end
            end
            if (emit_now) begin
                state_q     <= StEmit;
                valid_q     <= 1'b1;
                udt_state_q <= BROKEN_CODE;
            end else if (drop_now) begin
                state_q <= StIdle;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign close_tready_o = tready_q;
    assign state_valid_o  = valid_q;
    assign udt_state_o    = udt_state_q;
    assign conn_idx_o     = conn_idx_q;
    assign close_ts_o     = close_ts_q;
    assign close_cnt_o    = close_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_udt_close_handler.sv
// Bench for udt_close_handler: drives a 64-bit and a 128-bit instance in turn with directed and
// random CLOSE traffic and compares against a packet-level reference model.
module tb_udt_close_handler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic [127:0] tdata = '0;
    logic [15:0]  tkeep = '0;
    logic [127:0] conn_id = '0;
    logic [3:0]   conn_act = '0;
    logic         ready = 1'b0;
    int           mode = 0;

    logic         rdy [2];
    logic [31:0]  st  [2];
    logic [1:0]   idx [2];
    logic [31:0]  ts  [2];
    logic         vld [2];
    logic [15:0]  ccnt[2];
    logic [15:0]  dcnt[2];

    int unsigned  exp_close[2];
    int unsigned  exp_drop[2];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    udt_close_handler #(.DATA_W(64)) dut64 (
        .core_clk       (clk),
        .core_rst_n     (rst_n),
        .close_tvalid_i (tvalid && (mode == 0)),
        .close_tdata_i  (tdata[63:0]),
        .close_tkeep_i  (tkeep[7:0]),
        .close_tlast_i  (tlast),
        .close_tready_o (rdy[0]),
        .conn_sock_id_i (conn_id),
        .conn_active_i  (conn_act),
        .udt_state_o    (st[0]),
        .conn_idx_o     (idx[0]),
        .close_ts_o     (ts[0]),
        .state_valid_o  (vld[0]),
        .state_ready_i  (ready),
        .close_cnt_o    (ccnt[0]),
        .drop_cnt_o     (dcnt[0])
    );

    udt_close_handler #(.DATA_W(128)) dut128 (
        .core_clk       (clk),
        .core_rst_n     (rst_n),
        .close_tvalid_i (tvalid && (mode == 1)),
        .close_tdata_i  (tdata),
        .close_tkeep_i  (tkeep),
        .close_tlast_i  (tlast),
        .close_tready_o (rdy[1]),
        .conn_sock_id_i (conn_id),
        .conn_active_i  (conn_act),
        .udt_state_o    (st[1]),
        .conn_idx_o     (idx[1]),
        .close_ts_o     (ts[1]),
        .state_valid_o  (vld[1]),
        .state_ready_i  (ready),
        .close_cnt_o    (ccnt[1]),
        .drop_cnt_o     (dcnt[1])
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (mode %0d): observed %0h expected %0h", tag, mode, obs, exp);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= 32'd65535) ? 32'd65535 : v + 1;
    endfunction

    task automatic check_counters();
        check("close_cnt", ccnt[mode], exp_close[mode]);
        check("drop_cnt", dcnt[mode], exp_drop[mode]);
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [15:0] kp, input logic last);
        bit done = 0;
        tdata  = d;
        tkeep  = kp;
        tlast  = last;
        tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = rdy[mode];
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        if (!done) check("beat_timeout", 0, 1);
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scramble_conn();
        conn_act = 4'($urandom);
        for (int k = 0; k < 4; k++) conn_id[32*k +: 32] = $urandom;
    endtask

    task automatic set_table();
        conn_id  = {32'h0000_5555, 32'h0000_1234, 32'h0000_2222, 32'h0000_1111};
        conn_act = 4'b0111;
    endtask

    // bad_keep: 0 none, 1 first header beat short, 2 second header beat short (64-bit only)
    task automatic do_packet(input logic [127:0] hdr, input int bad_keep, input int extras,
                             input bit runt, input int bp);
        bit          ok = 0;
        int          exp_idx = 0;
        logic [31:0] exp_ts = hdr[63:32];
        if (!runt && hdr[127] && hdr[126:112] == 15'd5 && bad_keep == 0) begin
            for (int k = 0; k < 4; k++) begin
                if (!ok && conn_act[k] && conn_id[32*k +: 32] == hdr[31:0]) begin
                    ok      = 1;
                    exp_idx = k;
                end
            end
        end
        if (mode == 0) begin
            if (runt) begin
                send_beat({64'h0, hdr[127:64]}, 16'h00FF, 1'b1);
            end else begin
                send_beat({64'h0, hdr[127:64]}, (bad_keep == 1) ? 16'h000F : 16'h00FF, 1'b0);
                gap();
                send_beat({64'h0, hdr[63:0]}, (bad_keep == 2) ? 16'h000F : 16'h00FF,
                          extras == 0);
            end
        end else begin
            send_beat(hdr, (bad_keep != 0) ? 16'h0FFF : 16'hFFFF, extras == 0);
        end
        if (!runt) begin
            scramble_conn();
            for (int e = 0; e < extras; e++) begin
                gap();
                send_beat({$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                          e == extras - 1);
            end
        end
        if (ok) begin
            check("valid_after_last", vld[mode], 1);
            check("udt_state", st[mode], 32'd6);
            check("conn_idx", idx[mode], exp_idx);
            check("close_ts", ts[mode], exp_ts);
            check("tready_in_emit", rdy[mode], 0);
            ready = 1'b0;
            for (int c = 0; c < bp; c++) begin
                @(posedge clk);
                #1;
                check("bp_valid", vld[mode], 1);
                check("bp_idx", idx[mode], exp_idx);
                check("bp_ts", ts[mode], exp_ts);
                check("bp_tready", rdy[mode], 0);
            end
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
            exp_close[mode] = sat_inc(exp_close[mode]);
            check("valid_after_hs", vld[mode], 0);
            check("tready_after_hs", rdy[mode], 1);
        end else begin
            exp_drop[mode] = sat_inc(exp_drop[mode]);
            check("no_valid_on_drop", vld[mode], 0);
            check("tready_after_drop", rdy[mode], 1);
        end
        check_counters();
    endtask

    task automatic run_suite();
        logic [127:0] good = {64'h8005_0000_0000_0000, 64'hCAFE_0001_0000_1234};
        set_table(); do_packet(good, 0, 0, 0, 20);
        set_table(); do_packet({64'h8002_0000_0000_0000, 64'hCAFE_0001_0000_1234}, 0, 0, 0, 0);
        set_table(); do_packet({64'h8005_0000_0000_0000, 64'hCAFE_0001_0000_9999}, 0, 0, 0, 0);
        set_table(); do_packet({64'h8005_0000_0000_0000, 64'hCAFE_0001_0000_5555}, 0, 0, 0, 0);
        if (mode == 0) begin
            set_table(); do_packet(good, 0, 0, 1, 0);
        end
        set_table(); do_packet(good, (mode == 0) ? 2 : 1, 0, 0, 0);
        set_table(); do_packet(good, 0, 3, 0, 2);
        for (int p = 0; p < 40; p++) begin
            logic [127:0] h;
            int           bk = 0;
            bit           rt;
            for (int k = 0; k < 4; k++) begin
                conn_id[32*k +: 32] = 32'h1000 + $urandom_range(0, 5);
                conn_act[k]         = 1'($urandom_range(0, 1));
            end
            h[127]     = ($urandom_range(0, 9) != 0);
            h[126:112] = ($urandom_range(0, 9) != 0) ? 15'd5 : 15'($urandom);
            h[111:64]  = {16'($urandom), $urandom};
            h[63:32]   = $urandom;
            h[31:0]    = 32'h1000 + $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) bk = (mode == 0) ? $urandom_range(1, 2) : 1;
            rt = (mode == 0) && ($urandom_range(0, 9) == 0);
            do_packet(h, bk, $urandom_range(0, 3), rt, $urandom_range(0, 4));
        end
    endtask

    initial begin
        exp_close = '{0, 0};
        exp_drop  = '{0, 0};
        #1;
        for (int m = 0; m < 2; m++) begin
            mode = m;
            check("rst_tready", rdy[m], 0);
            check("rst_valid", vld[m], 0);
            check("rst_state", st[m], 0);
            check("rst_idx", idx[m], 0);
            check("rst_ts", ts[m], 0);
            check_counters();
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready_held", rdy[0], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mode = 0;
        check("tready_after_rst", rdy[0], 1);

        mode = 0;
        run_suite();
        mode = 1;
        run_suite();

        // Asynchronous reset while a record is pending.
        set_table();
        send_beat({64'h8005_0000_0000_0000, 64'hBEEF_0002_0000_2222}, 16'hFFFF, 1'b1);
        check("mid_emit_valid", vld[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_close = '{0, 0};
        exp_drop  = '{0, 0};
        check("async_valid", vld[1], 0);
        check("async_state", st[1], 0);
        check("async_idx", idx[1], 0);
        check("async_ts", ts[1], 0);
        check("async_tready", rdy[1], 0);
        check_counters();
        mode = 0;
        check_counters();
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_post_rst64", rdy[0], 1);
        check("tready_post_rst128", rdy[1], 1);

        // Back-to-back runts on the 64-bit instance push the drop counter past saturation.
        mode   = 0;
        tdata  = '0;
        tkeep  = 16'h00FF;
        tlast  = 1'b1;
        tvalid = 1'b1;
        for (int n = 0; n < 65539; n++) begin
            @(posedge clk);
            exp_drop[0] = sat_inc(exp_drop[0]);
        end
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        check("drop_saturated", dcnt[0], exp_drop[0]);
        check("drop_all_ones", dcnt[0], 16'hFFFF);
        check("close_after_sat", ccnt[0], exp_close[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
